multi_cycle_control: RTL and testbench

Sequencing FSM for the multi-cycle RISC-V core. It replaces the single-cycle opcode decoder with a per-instruction state machine that time-shares one ALU and one unified instruction/data memory port across fetch, decode, execute, memory and writeback cycles. It handles variable-latency memory through a ready handshake with a timeout, and it traps on unsupported opcodes.

---
 rtl/multi_cycle_control.sv | 200 ++++++++++++++++++++
 tb/tb_multi_cycle_control.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control.sv
// Sequencing FSM for the multi-cycle RISC-V core: one shared ALU and one unified memory port,
// a ready handshake with a bounded wait, and sticky trap causes for illegal opcodes and bus errors.
module multi_cycle_control #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] OP_i,
   input  logic       Zero_i,
   input  logic       Mem_Ready_i,
   output logic       PC_Write_o,
   output logic       IR_Write_o,
   output logic       I_or_D_o,
   output logic       Mem_Read_o,
   output logic       Mem_Write_o,
   output logic       Reg_Write_o,
   output logic [1:0] Mem_to_Reg_o,
   output logic [1:0] ALU_Src_A_o,
   output logic [1:0] ALU_Src_B_o,
   output logic [2:0] ALU_Op_o,
   output logic       PC_Src_o,
   output logic       Branch_o,
   output logic       Jal_o,
   output logic       Retired_o,
   output logic       Illegal_o,
   output logic       Bus_Err_o
);

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_FETCH     = 4'd1;
   localparam logic [3:0] S_DECODE    = 4'd2;
   localparam logic [3:0] S_EXEC_R    = 4'd3;
   localparam logic [3:0] S_EXEC_I    = 4'd4;
   localparam logic [3:0] S_EXEC_LUI  = 4'd5;
   localparam logic [3:0] S_ALU_WB    = 4'd6;
   localparam logic [3:0] S_MEM_ADDR  = 4'd7;
   localparam logic [3:0] S_MEM_READ  = 4'd8;
   localparam logic [3:0] S_MEM_WB    = 4'd9;
   localparam logic [3:0] S_MEM_WRITE = 4'd10;
   localparam logic [3:0] S_BRANCH    = 4'd11;
   localparam logic [3:0] S_JAL       = 4'd12;
   localparam logic [3:0] S_TRAP      = 4'd13;

   localparam logic [6:0] OP_R   = 7'h33;
   localparam logic [6:0] OP_I   = 7'h13;
   localparam logic [6:0] OP_LUI = 7'h37;
   localparam logic [6:0] OP_SW  = 7'h23;
   localparam logic [6:0] OP_LW  = 7'h03;
   localparam logic [6:0] OP_JAL = 7'h6F;
   localparam logic [6:0] OP_BEQ = 7'h63;

   localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

   logic [3:0] state;
   logic [3:0] next_state;
   logic [7:0] wait_cnt;
   logic       wait_state;
   logic       timed_out;
   logic       set_illegal;
   logic       illegal_q;
   logic       bus_err_q;

   // A zero timeout disables the bus-error trap; a ready in the limit cycle still completes.
   assign wait_state = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
   assign timed_out  = wait_state && !Mem_Ready_i && (MEM_TIMEOUT != 0) && (wait_cnt == TIMEOUT_LAST);
   assign Illegal_o  = illegal_q;
   assign Bus_Err_o  = bus_err_q;

   always_comb begin
      next_state   = state;
      set_illegal  = 1'b0;
      PC_Write_o   = 1'b0;
      IR_Write_o   = 1'b0;
      I_or_D_o     = 1'b0;
      Mem_Read_o   = 1'b0;
      Mem_Write_o  = 1'b0;
      Reg_Write_o  = 1'b0;
      Mem_to_Reg_o = 2'b00;
      ALU_Src_A_o  = 2'b00;
      ALU_Src_B_o  = 2'b00;
      ALU_Op_o     = 3'b000;
      PC_Src_o     = 1'b0;
      Branch_o     = 1'b0;
      Jal_o        = 1'b0;
      Retired_o    = 1'b0;
      case (state)
         S_IDLE: next_state = S_FETCH;
         S_FETCH: begin
            Mem_Read_o  = 1'b1;
            ALU_Src_B_o = 2'b01;
            ALU_Op_o    = 3'b111;
            if (Mem_Ready_i) begin
               IR_Write_o = 1'b1;
               PC_Write_o = 1'b1;
               next_state = S_DECODE;
            end
         end
         S_DECODE: begin
            ALU_Src_A_o = 2'b01;
            ALU_Src_B_o = 2'b10;
            ALU_Op_o    = 3'b111;
            case (OP_i)
               OP_R:         next_state = S_EXEC_R;
               OP_I:         next_state = S_EXEC_I;
               OP_LUI:       next_state = S_EXEC_LUI;
               OP_LW, OP_SW: next_state = S_MEM_ADDR;
               OP_BEQ:       next_state = S_BRANCH;
               OP_JAL:       next_state = S_JAL;
               default: begin
                  next_state  = S_TRAP;
                  set_illegal = 1'b1;
               end
            endcase
         end
         S_EXEC_R: begin
            ALU_Src_A_o = 2'b10;
            next_state  = S_ALU_WB;
         end
         S_EXEC_I, S_EXEC_LUI: begin
            ALU_Src_A_o = 2'b10;
            ALU_Src_B_o = 2'b10;
            ALU_Op_o    = (state == S_EXEC_I) ? 3'b001 : 3'b010;
            next_state  = S_ALU_WB;
         end
         S_ALU_WB: begin
            Reg_Write_o = 1'b1;
            Retired_o   = 1'b1;
            next_state  = S_FETCH;
         end
         S_MEM_ADDR: begin
            ALU_Src_A_o = 2'b10;
            ALU_Src_B_o = 2'b10;
            if (OP_i == OP_SW) begin
               ALU_Op_o   = 3'b011;
               next_state = S_MEM_WRITE;
            end else begin
               ALU_Op_o   = 3'b100;
               next_state = S_MEM_READ;
            end
         end
         S_MEM_READ: begin
            I_or_D_o   = 1'b1;
            Mem_Read_o = 1'b1;
            if (Mem_Ready_i) next_state = S_MEM_WB;
         end
         S_MEM_WB: begin
            Reg_Write_o  = 1'b1;
            Mem_to_Reg_o = 2'b01;
            Retired_o    = 1'b1;
            next_state   = S_FETCH;
         end
         S_MEM_WRITE: begin
            I_or_D_o    = 1'b1;
            Mem_Write_o = 1'b1;
            if (Mem_Ready_i) begin
               Retired_o  = 1'b1;
               next_state = S_FETCH;
            end
         end
         S_BRANCH: begin
            ALU_Src_A_o = 2'b10;
            ALU_Op_o    = 3'b110;
            Branch_o    = 1'b1;
            PC_Src_o    = 1'b1;
            PC_Write_o  = Zero_i;
            Retired_o   = 1'b1;
            next_state  = S_FETCH;
         end
         S_JAL: begin
            Jal_o        = 1'b1;
            PC_Src_o     = 1'b1;
            PC_Write_o   = 1'b1;
            Reg_Write_o  = 1'b1;
            Mem_to_Reg_o = 2'b10;
            ALU_Op_o     = 3'b101;
            Retired_o    = 1'b1;
            next_state   = S_FETCH;
         end
         S_TRAP:  next_state = S_TRAP;
         default: next_state = S_IDLE;
      endcase
      if (timed_out) next_state = S_TRAP;
   end

   // The wait counter runs only while a memory-wait state sees ready low, so every entry starts from zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         wait_cnt  <= 8'd0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state    <= next_state;
         wait_cnt <= (wait_state && !Mem_Ready_i) ? wait_cnt + 8'd1 : 8'd0;
         if (set_illegal) illegal_q <= 1'b1;
         if (timed_out)   bus_err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Table-driven bench for multi_cycle_control: per-cycle expected output vectors go through a
// scoreboard queue, plus hand-written checks for asynchronous reset behaviour.
module tb_multi_cycle_control;

   typedef struct packed {
      logic       pc_write;
      logic       ir_write;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic [1:0] mem_to_reg;
      logic [1:0] src_a;
      logic [1:0] src_b;
      logic [2:0] alu_op;
      logic       pc_src;
      logic       branch;
      logic       jal;
      logic       retired;
      logic       illegal;
      logic       bus_err;
   } outs_t;

   typedef struct {
      string      tag;
      logic       rst;
      logic [6:0] op;
      logic       zero;
      logic       rdy;
      outs_t      exp;
   } vec_t;

   logic       clk;
   logic       reset;
   logic [6:0] op;
   logic       zero;
   logic       ready;
   logic       pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write;
   logic [1:0] mem_to_reg, src_a, src_b;
   logic [2:0] alu_op;
   logic       pc_src, branch, jal, retired, illegal, bus_err;
   outs_t      act;

   int checks = 0;
   int errors = 0;
   vec_t vecs[$];
   vec_t sb[$];
   int mid_idx;

   multi_cycle_control #(.MEM_TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .OP_i(op), .Zero_i(zero), .Mem_Ready_i(ready),
      .PC_Write_o(pc_write), .IR_Write_o(ir_write), .I_or_D_o(i_or_d),
      .Mem_Read_o(mem_read), .Mem_Write_o(mem_write), .Reg_Write_o(reg_write),
      .Mem_to_Reg_o(mem_to_reg), .ALU_Src_A_o(src_a), .ALU_Src_B_o(src_b),
      .ALU_Op_o(alu_op), .PC_Src_o(pc_src), .Branch_o(branch), .Jal_o(jal),
      .Retired_o(retired), .Illegal_o(illegal), .Bus_Err_o(bus_err)
   );

   assign act = {pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, mem_to_reg,
                 src_a, src_b, alu_op, pc_src, branch, jal, retired, illegal, bus_err};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected output patterns per controller state, written straight from the state table.
   function automatic outs_t st_zero();
      outs_t o = '0;
      return o;
   endfunction
   function automatic outs_t st_fetch(logic rdy);
      outs_t o = '0;
      o.mem_read = 1'b1; o.src_b = 2'b01; o.alu_op = 3'b111;
      o.pc_write = rdy;  o.ir_write = rdy;
      return o;
   endfunction
   function automatic outs_t st_decode();
      outs_t o = '0;
      o.src_a = 2'b01; o.src_b = 2'b10; o.alu_op = 3'b111;
      return o;
   endfunction
   function automatic outs_t st_alu(logic [1:0] b, logic [2:0] aop);
      outs_t o = '0;
      o.src_a = 2'b10; o.src_b = b; o.alu_op = aop;
      return o;
   endfunction
   function automatic outs_t st_wb(logic [1:0] m2r);
      outs_t o = '0;
      o.reg_write = 1'b1; o.mem_to_reg = m2r; o.retired = 1'b1;
      return o;
   endfunction
   function automatic outs_t st_mem_read();
      outs_t o = '0;
      o.i_or_d = 1'b1; o.mem_read = 1'b1;
      return o;
   endfunction
   function automatic outs_t st_mem_write(logic rdy);
      outs_t o = '0;
      o.i_or_d = 1'b1; o.mem_write = 1'b1; o.retired = rdy;
      return o;
   endfunction
   function automatic outs_t st_branch(logic z);
      outs_t o = '0;
      o.src_a = 2'b10; o.alu_op = 3'b110; o.branch = 1'b1; o.pc_src = 1'b1;
      o.pc_write = z; o.retired = 1'b1;
      return o;
   endfunction
   function automatic outs_t st_jal();
      outs_t o = '0;
      o.jal = 1'b1; o.pc_src = 1'b1; o.pc_write = 1'b1; o.reg_write = 1'b1;
      o.mem_to_reg = 2'b10; o.alu_op = 3'b101; o.retired = 1'b1;
      return o;
   endfunction
   function automatic outs_t st_trap(logic ill, logic bus);
      outs_t o = '0;
      o.illegal = ill; o.bus_err = bus;
      return o;
   endfunction

   task automatic add(string tag, logic rst, logic [6:0] vop, logic z, logic rdy, outs_t exp);
      vec_t v;
      v.tag = tag; v.rst = rst; v.op = vop; v.zero = z; v.rdy = rdy; v.exp = exp;
      vecs.push_back(v);
   endtask

   task automatic compare_outs(string tag, outs_t got, outs_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic apply_stimulus(vec_t v);
      @(posedge clk);
      #1;
      reset = v.rst; op = v.op; zero = v.zero; ready = v.rdy;
      sb.push_back(v);
   endtask

   task automatic check_output();
      vec_t e;
      @(negedge clk);
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("[TB] FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
         e = sb.pop_front();
         compare_outs(e.tag, act, e.exp);
      end
   endtask

   initial begin
      reset = 1'b1; op = 7'h00; zero = 1'b0; ready = 1'b0;

      // R-type, all memory ready
      add("r_idle",   1, 7'h33, 0, 1, st_zero());
      add("r_fetch",  1, 7'h33, 0, 1, st_fetch(1));
      add("r_decode", 1, 7'h33, 0, 1, st_decode());
      add("r_exec",   1, 7'h33, 0, 1, st_alu(2'b00, 3'b000));
      add("r_wb",     1, 7'h33, 0, 1, st_wb(2'b00));
      // LW with two fetch waits and three read waits: retires in the 10th cycle
      add("lw_fetch_w1", 1, 7'h03, 0, 0, st_fetch(0));
      add("lw_fetch_w2", 1, 7'h03, 0, 0, st_fetch(0));
      add("lw_fetch",    1, 7'h03, 0, 1, st_fetch(1));
      add("lw_decode",   1, 7'h03, 0, 1, st_decode());
      add("lw_addr",     1, 7'h03, 0, 1, st_alu(2'b10, 3'b100));
      for (int i = 0; i < 3; i++) add("lw_read_wait", 1, 7'h03, 0, 0, st_mem_read());
      add("lw_read",     1, 7'h03, 0, 1, st_mem_read());
      add("lw_wb",       1, 7'h03, 0, 1, st_wb(2'b01));
      // BEQ taken and not taken
      add("beq1_fetch",  1, 7'h63, 1, 1, st_fetch(1));
      add("beq1_decode", 1, 7'h63, 1, 1, st_decode());
      add("beq1_branch", 1, 7'h63, 1, 1, st_branch(1));
      add("beq0_fetch",  1, 7'h63, 0, 1, st_fetch(1));
      add("beq0_decode", 1, 7'h63, 0, 1, st_decode());
      add("beq0_branch", 1, 7'h63, 0, 1, st_branch(0));
      // JAL, I-logic, LUI
      add("jal_fetch",   1, 7'h6F, 0, 1, st_fetch(1));
      add("jal_decode",  1, 7'h6F, 0, 1, st_decode());
      add("jal_state",   1, 7'h6F, 0, 1, st_jal());
      add("i_fetch",     1, 7'h13, 0, 1, st_fetch(1));
      add("i_decode",    1, 7'h13, 0, 1, st_decode());
      add("i_exec",      1, 7'h13, 0, 1, st_alu(2'b10, 3'b001));
      add("i_wb",        1, 7'h13, 0, 1, st_wb(2'b00));
      add("lui_fetch",   1, 7'h37, 0, 1, st_fetch(1));
      add("lui_decode",  1, 7'h37, 0, 1, st_decode());
      add("lui_exec",    1, 7'h37, 0, 1, st_alu(2'b10, 3'b010));
      add("lui_wb",      1, 7'h37, 0, 1, st_wb(2'b00));
      // SW with ready arriving in the last allowed cycle
      add("sw_fetch",    1, 7'h23, 0, 1, st_fetch(1));
      add("sw_decode",   1, 7'h23, 0, 1, st_decode());
      add("sw_addr",     1, 7'h23, 0, 1, st_alu(2'b10, 3'b011));
      for (int i = 0; i < 3; i++) add("sw_write_wait", 1, 7'h23, 0, 0, st_mem_write(0));
      add("sw_write_last", 1, 7'h23, 0, 1, st_mem_write(1));
      // SW timing out into a bus-error trap
      add("swto_fetch",  1, 7'h23, 0, 1, st_fetch(1));
      add("swto_decode", 1, 7'h23, 0, 1, st_decode());
      add("swto_addr",   1, 7'h23, 0, 1, st_alu(2'b10, 3'b011));
      for (int i = 0; i < 4; i++) add("swto_write_wait", 1, 7'h23, 0, 0, st_mem_write(0));
      add("swto_trap1",  1, 7'h23, 0, 1, st_trap(0, 1));
      add("swto_trap2",  1, 7'h23, 0, 1, st_trap(0, 1));
      add("swto_reset",  0, 7'h23, 0, 1, st_zero());
      // Illegal opcode
      add("ill_idle",    1, 7'h7F, 0, 1, st_zero());
      add("ill_fetch",   1, 7'h7F, 0, 1, st_fetch(1));
      add("ill_decode",  1, 7'h7F, 0, 1, st_decode());
      add("ill_trap1",   1, 7'h7F, 0, 1, st_trap(1, 0));
      add("ill_trap2",   1, 7'h7F, 0, 1, st_trap(1, 0));
      add("ill_reset",   0, 7'h7F, 0, 1, st_zero());
      // Run up to a pending store; the reset lands by hand below
      add("mw_idle",     1, 7'h23, 0, 1, st_zero());
      add("mw_fetch",    1, 7'h23, 0, 1, st_fetch(1));
      add("mw_decode",   1, 7'h23, 0, 1, st_decode());
      add("mw_addr",     1, 7'h23, 0, 1, st_alu(2'b10, 3'b011));
      add("mw_write",    1, 7'h23, 0, 0, st_mem_write(0));
      mid_idx = vecs.size();
      // Restart after reset; fetch sees ready only in its last allowed cycle
      add("rs_idle",     1, 7'h33, 0, 0, st_zero());
      for (int i = 0; i < 3; i++) add("rs_fetch_wait", 1, 7'h33, 0, 0, st_fetch(0));
      add("rs_fetch",    1, 7'h33, 0, 1, st_fetch(1));
      add("rs_decode",   1, 7'h33, 0, 1, st_decode());
      add("rs_exec",     1, 7'h33, 0, 1, st_alu(2'b00, 3'b000));
      add("rs_wb",       1, 7'h33, 0, 1, st_wb(2'b00));

      #2 reset = 1'b0;
      #1 compare_outs("reset_async", act, st_zero());
      @(negedge clk);
      compare_outs("reset_hold", act, st_zero());

      for (int i = 0; i < mid_idx; i++) begin
         apply_stimulus(vecs[i]);
         check_output();
      end

      // Reset between edges must drop the store strobe immediately
      @(posedge clk);
      #2;
      compare_outs("mw_before_reset", act, st_mem_write(0));
      reset = 1'b0;
      #1;
      compare_outs("mw_async_drop", act, st_zero());

      for (int i = mid_idx; i < vecs.size(); i++) begin
         apply_stimulus(vecs[i]);
         check_output();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
